// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge sequencer: turns each decoded AHB transfer into one APB
// SETUP+ENABLE access and stalls the AHB master through Hreadyout.
module apb_fsm_controller #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SLAVES = 4
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic [WIDTH-1:0]  Haddr1,
    input  logic              Hwrite,
    input  logic [WIDTH-1:0]  Hwdata,
    input  logic [SLAVES-1:0] tempselx,
    output logic [WIDTH-1:0]  Paddr_in,
    output logic              Pwrite_in,
    output logic [WIDTH-1:0]  Pwdata_in,
    output logic [SLAVES-1:0] Pselx_in,
    output logic              Penable_in,
    output logic              Hreadyout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WWAIT   = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        RENABLE = 3'd4,
        WENABLE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [SLAVES-1:0] sel_q, sel_d;
    logic [WIDTH-1:0]  paddr_d;
    logic              pwrite_d;
    logic [WIDTH-1:0]  pwdata_d;
    logic [SLAVES-1:0] psel_d;
    logic              penable_d;
    logic              hready_d;

    // State, write-address holding registers and all registered outputs
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            sel_q      <= '0;
            Paddr_in   <= '0;
            Pwrite_in  <= 1'b0;
            Pwdata_in  <= '0;
            Pselx_in   <= '0;
            Penable_in <= 1'b0;
            Hreadyout  <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            Paddr_in   <= paddr_d;
            Pwrite_in  <= pwrite_d;
            Pwdata_in  <= pwdata_d;
            Pselx_in   <= psel_d;
            Penable_in <= penable_d;
            Hreadyout  <= hready_d;
        end
    end

    // Next state and next registered output values
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        paddr_d   = Paddr_in;
        pwrite_d  = Pwrite_in;
        pwdata_d  = Pwdata_in;
        psel_d    = Pselx_in;
        penable_d = Penable_in;
        hready_d  = Hreadyout;

        case (state_q)
            IDLE, RENABLE, WENABLE: begin
                // AHB-ready states: accept a new transfer or drop back to idle
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
                if (valid) begin
                    hready_d = 1'b0;
                    if (Hwrite) begin
                        // Write data arrives next cycle, so park the address
                        state_d = WWAIT;
                        addr_d  = Haddr1;
                        sel_d   = tempselx;
                    end else begin
                        state_d  = READ;
                        paddr_d  = Haddr1;
                        psel_d   = tempselx;
                        pwrite_d = 1'b0;
                    end
                end
            end
            WWAIT: begin
                state_d   = WRITE;
                paddr_d   = addr_q;
                psel_d    = sel_q;
                pwdata_d  = Hwdata;
                pwrite_d  = 1'b1;
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end
            READ: begin
                state_d   = RENABLE;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
            WRITE: begin
                state_d   = WENABLE;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Self-checking bench for apb_fsm_controller: per-cycle vector table feeding a
// scoreboard queue, plus a hand-written asynchronous reset during WENABLE.
module tb_apb_fsm_controller;

    logic        Hclk;
    logic        Hresetn;
    logic        valid;
    logic [31:0] Haddr1;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic [3:0]  tempselx;
    logic [31:0] Paddr_in;
    logic        Pwrite_in;
    logic [31:0] Pwdata_in;
    logic [3:0]  Pselx_in;
    logic        Penable_in;
    logic        Hreadyout;

    int n_checks = 0;
    int n_fail   = 0;

    apb_fsm_controller #(.WIDTH(32), .SLAVES(4)) dut (
        .Hclk       (Hclk),
        .Hresetn    (Hresetn),
        .valid      (valid),
        .Haddr1     (Haddr1),
        .Hwrite     (Hwrite),
        .Hwdata     (Hwdata),
        .tempselx   (tempselx),
        .Paddr_in   (Paddr_in),
        .Pwrite_in  (Pwrite_in),
        .Pwdata_in  (Pwdata_in),
        .Pselx_in   (Pselx_in),
        .Penable_in (Penable_in),
        .Hreadyout  (Hreadyout)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  psel;
        logic        penable;
        logic        hready;
    } exp_t;

    typedef struct {
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic v, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                logic [31:0] ea, logic ew, logic [31:0] ed, logic [3:0] es,
                                logic ee, logic er);
        vec_t r;
        r.v = v; r.w = w; r.a = a; r.d = d; r.s = s;
        r.e.paddr = ea; r.e.pwrite = ew; r.e.pwdata = ed;
        r.e.psel = es; r.e.penable = ee; r.e.hready = er;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cmp(string tag, exp_t e);
        check({tag, " Paddr_in"},   Paddr_in,          e.paddr);
        check({tag, " Pwrite_in"},  32'(Pwrite_in),    32'(e.pwrite));
        check({tag, " Pwdata_in"},  Pwdata_in,         e.pwdata);
        check({tag, " Pselx_in"},   32'(Pselx_in),     32'(e.psel));
        check({tag, " Penable_in"}, 32'(Penable_in),   32'(e.penable));
        check({tag, " Hreadyout"},  32'(Hreadyout),    32'(e.hready));
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge
    task automatic apply(string tag, vec_t v);
        exp_t e;
        @(negedge Hclk);
        valid = v.v; Hwrite = v.w; Haddr1 = v.a; Hwdata = v.d; tempselx = v.s;
        sb.push_back(v.e);
        @(posedge Hclk);
        #1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            cmp(tag, e);
        end
    endtask

    initial begin
        exp_t rst_e;
        rst_e.paddr = 32'h0; rst_e.pwrite = 1'b0; rst_e.pwdata = 32'h0;
        rst_e.psel = 4'h0; rst_e.penable = 1'b0; rst_e.hready = 1'b1;

        Hresetn = 1'b0; valid = 1'b0; Hwrite = 1'b0;
        Haddr1 = '0; Hwdata = '0; tempselx = '0;

        //           v  w  Haddr1        Hwdata        sel     Paddr         Pwr Pwdata        Psel   En Rdy
        // single read
        vecs.push_back(mk(1, 0, 32'h8000_0010, 32'h0,        4'b0001, 32'h8000_0010, 0, 32'h0,        4'b0001, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h8000_0010, 0, 32'h0,        4'b0001, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h8000_0010, 0, 32'h0,        4'b0000, 0, 1));
        // single write
        vecs.push_back(mk(1, 1, 32'h8400_0004, 32'h0,        4'b0010, 32'h8000_0010, 0, 32'h0,        4'b0000, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'hDEAD_BEEF, 4'b0000, 32'h8400_0004, 1, 32'hDEAD_BEEF, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h8400_0004, 1, 32'hDEAD_BEEF, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h8400_0004, 1, 32'hDEAD_BEEF, 4'b0000, 0, 1));
        // back-to-back read -> write (valid in RENABLE), then write -> read (valid in WENABLE)
        vecs.push_back(mk(1, 0, 32'h8000_0020, 32'h0,        4'b0001, 32'h8000_0020, 0, 32'hDEAD_BEEF, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h8000_0020, 0, 32'hDEAD_BEEF, 4'b0001, 1, 1));
        vecs.push_back(mk(1, 1, 32'h8800_0008, 32'h0,        4'b0100, 32'h8000_0020, 0, 32'hDEAD_BEEF, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h1234_5678, 4'b0000, 32'h8800_0008, 1, 32'h1234_5678, 4'b0100, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h8800_0008, 1, 32'h1234_5678, 4'b0100, 1, 1));
        vecs.push_back(mk(1, 0, 32'h8C00_000C, 32'h0,        4'b1000, 32'h8C00_000C, 0, 32'h1234_5678, 4'b1000, 0, 0));
        // valid during READ is ignored
        vecs.push_back(mk(1, 1, 32'hFFFF_FFF0, 32'h0,        4'b0001, 32'h8C00_000C, 0, 32'h1234_5678, 4'b1000, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h8C00_000C, 0, 32'h1234_5678, 4'b0000, 0, 1));
        // valid during WWAIT and WRITE is ignored
        vecs.push_back(mk(1, 1, 32'h8400_0010, 32'h0,        4'b0010, 32'h8C00_000C, 0, 32'h1234_5678, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 0, 32'hFFFF_FFF0, 32'hCAFE_F00D, 4'b1000, 32'h8400_0010, 1, 32'hCAFE_F00D, 4'b0010, 0, 0));
        vecs.push_back(mk(1, 0, 32'hFFFF_FFF0, 32'h0,        4'b1000, 32'h8400_0010, 1, 32'hCAFE_F00D, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h8400_0010, 1, 32'hCAFE_F00D, 4'b0000, 0, 1));
        // tempselx == 0 still sequenced
        vecs.push_back(mk(1, 0, 32'h9000_0000, 32'h0,        4'b0000, 32'h9000_0000, 0, 32'hCAFE_F00D, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h9000_0000, 0, 32'hCAFE_F00D, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'h9000_0000, 0, 32'hCAFE_F00D, 4'b0000, 0, 1));
        // non-one-hot select passes through
        vecs.push_back(mk(1, 0, 32'hA000_0000, 32'h0,        4'b0110, 32'hA000_0000, 0, 32'hCAFE_F00D, 4'b0110, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'hA000_0000, 0, 32'hCAFE_F00D, 4'b0110, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,         32'h0,        4'b0000, 32'hA000_0000, 0, 32'hCAFE_F00D, 4'b0000, 0, 1));

        // reset values
        repeat (2) @(posedge Hclk);
        #1;
        cmp("reset", rst_e);
        @(negedge Hclk);
        Hresetn = 1'b1;

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // async reset in the middle of WENABLE
        apply("rst_seq wwait", mk(1, 1, 32'hB000_0004, 32'h0, 4'b0010,
                                  32'hA000_0000, 0, 32'hCAFE_F00D, 4'b0000, 0, 0));
        apply("rst_seq setup", mk(0, 0, 32'h0, 32'h5555_AAAA, 4'b0000,
                                  32'hB000_0004, 1, 32'h5555_AAAA, 4'b0010, 0, 0));
        apply("rst_seq enable", mk(1, 0, 32'h0, 32'h0, 4'b0001,
                                   32'hB000_0004, 1, 32'h5555_AAAA, 4'b0010, 1, 1));
        #2;
        Hresetn = 1'b0;
        #1;
        cmp("async_reset", rst_e);
        valid = 1'b0;
        @(negedge Hclk);
        Hresetn = 1'b1;
        apply("post_reset idle", mk(0, 0, 32'h0, 32'h0, 4'b0000,
                                    32'h0, 0, 32'h0, 4'b0000, 0, 1));
        apply("post_reset read", mk(1, 0, 32'hC000_0008, 32'h0, 4'b1000,
                                    32'hC000_0008, 0, 32'h0, 4'b1000, 0, 0));
        apply("post_reset enable", mk(0, 0, 32'h0, 32'h0, 4'b0000,
                                      32'hC000_0008, 0, 32'h0, 4'b1000, 1, 1));

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
